// File: rtl/frame_capture_writer.sv
// frame_capture_writer
//   Captures one camera frame (RGB565 stream) into the RGB444 frame buffer
//   through its write port A. A capture request arms the block; writing only
//   begins after the next frame boundary so a partial frame is never stored.
//   Every output is registered; a valid pixel appears on the write port one
//   cycle later.
//
//   Optional build macro: CAPTURE_CONTINUOUS_EN
//     defined   - back-to-back frames while capture_req stays high
//     undefined - single-shot capture
module frame_capture_writer #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk_25mhz,
    input  logic              reset_n,
    input  logic [15:0]       pixel_in,
    input  logic              pixel_valid,
    input  logic              frame_done,
    input  logic              capture_req,
    output logic [11:0]       memory_data,
    output logic [ADDR_W-1:0] memory_addr,
    output logic              memory_we,
    output logic              busy,
    output logic              capture_done,
    output logic              short_frame
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] count_next_s;
    logic              req_d_r;
    logic              req_rise_s;
    logic [11:0]       data_next_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic              we_next_s;
    logic              busy_next_s;
    logic              done_next_s;
    logic              short_next_s;

    // RGB565 -> RGB444 by keeping the top bits of each channel (no rounding).
    function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] px);
        return {px[15:12], px[10:7], px[4:1]};
    endfunction

    assign req_rise_s = capture_req & ~req_d_r;

    // Next-state, pixel counter and next values of every registered output.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        data_next_s  = memory_data;
        addr_next_s  = memory_addr;
        we_next_s    = 1'b0;
        short_next_s = short_frame;

        case (state_r)
            ST_IDLE: begin
                if (req_rise_s) begin
                    state_next_s = ST_ARMED;
                    short_next_s = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // Pixels here belong to a frame already in flight: dropped.
                if (frame_done) begin
                    state_next_s = ST_CAPTURE;
                    count_next_s = ADDR_ZERO;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (pixel_valid) begin
                    we_next_s    = 1'b1;
                    data_next_s  = rgb565_to_rgb444(pixel_in);
                    addr_next_s  = count_r;
                    count_next_s = count_r + ADDR_ONE;
                    if (count_r == LAST_ADDR) begin
                        // Frame complete, even if frame_done coincides.
                        state_next_s = ST_DONE;
                    end else if (frame_done) begin
                        short_next_s = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CAPTURE;
                    end
                end else if (frame_done) begin
                    short_next_s = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
`ifdef CAPTURE_CONTINUOUS_EN
                if (capture_req) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
`else
                state_next_s = ST_IDLE;
`endif
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

`ifdef CAPTURE_CONTINUOUS_EN
        // Stay busy across the DONE gap between back-to-back frames.
        busy_next_s = (state_next_s != ST_IDLE);
`else
        busy_next_s = (state_next_s == ST_ARMED) || (state_next_s == ST_CAPTURE);
`endif
        done_next_s = (state_next_s == ST_DONE);
    end

    // State, counter, request edge detector and registered outputs.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            count_r      <= ADDR_ZERO;
            req_d_r      <= 1'b0;
            memory_data  <= 12'h000;
            memory_addr  <= ADDR_ZERO;
            memory_we    <= 1'b0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
            short_frame  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            req_d_r      <= capture_req;
            memory_data  <= data_next_s;
            memory_addr  <= addr_next_s;
            memory_we    <= we_next_s;
            busy         <= busy_next_s;
            capture_done <= done_next_s;
            short_frame  <= short_next_s;
        end
    end

endmodule

// File: tb/tb_frame_capture_writer.sv
// tb_frame_capture_writer
//   Directed bench for frame_capture_writer using a reduced 16x8 frame so a
//   full frame is short. Observes the write port one step after each active
//   clock edge; expected addresses restart at 0 after each capture_done.
//   Honours the CAPTURE_CONTINUOUS_EN build macro for the multi-frame case.
module tb_frame_capture_writer;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int N  = H * V;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [15:0]   pixel_in;
    logic          pixel_valid;
    logic          frame_done;
    logic          capture_req;
    logic [11:0]   memory_data;
    logic [AW-1:0] memory_addr;
    logic          memory_we;
    logic          busy;
    logic          capture_done;
    logic          short_frame;

    int            n_cmp = 0;
    int            n_err = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    int            exp_addr = 0;
    logic [11:0]   exp_data = 12'h000;
    int            w0;
    int            d0;
    logic          busy_dropped;

    frame_capture_writer #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
        .clk_25mhz    (clk),
        .reset_n      (reset_n),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .capture_req  (capture_req),
        .memory_data  (memory_data),
        .memory_addr  (memory_addr),
        .memory_we    (memory_we),
        .busy         (busy),
        .capture_done (capture_done),
        .short_frame  (short_frame)
    );

    // Free-running 100 MHz-style bench clock.
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inspect the outputs produced by the edge just passed.
    task automatic observe();
        if (memory_we) begin
            check_value("wr_addr", 64'(memory_addr), 64'(exp_addr));
            check_value("wr_data", 64'(memory_data), 64'(exp_data));
            wr_cnt++;
            exp_addr++;
        end
        if (capture_done) begin
            done_cnt++;
            exp_addr = 0;
        end
    endtask

    task automatic send(input logic v, input logic [15:0] p, input logic fd, input logic rq);
        pixel_valid = v;
        pixel_in    = p;
        frame_done  = fd;
        capture_req = rq;
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic arm();
        send(1'b0, 16'h0000, 1'b0, 1'b1);
        send(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // Safety net: never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // 1: reset held with random inputs -> all outputs zero
        reset_n     = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = 16'h0000;
        frame_done  = 1'b0;
        capture_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pixel_valid = 1'($urandom);
            pixel_in    = 16'($urandom);
            frame_done  = 1'($urandom);
            capture_req = 1'($urandom);
            @(posedge clk);
            #1;
            check_value("reset_outputs",
                        {29'd0, memory_data, memory_addr, memory_we, busy, capture_done, short_frame},
                        64'd0);
        end
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
        capture_req = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);
        check_value("post_reset_busy", 64'(busy), 64'd0);

        // 2: full frame of 16'hFFFF -> N writes, data FFF, addr 0..N-1
        w0 = wr_cnt; d0 = done_cnt; exp_data = 12'hFFF;
        send(1'b0, 16'h0000, 1'b0, 1'b1);
        check_value("arm_busy", 64'(busy), 64'd1);
        send(1'b0, 16'h0000, 1'b0, 1'b0);
        send(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) send(1'b1, 16'hFFFF, 1'b0, 1'b0);
        idle(3);
        check_value("full_writes", 64'(wr_cnt - w0), 64'(N));
        check_value("full_done",   64'(done_cnt - d0), 64'd1);
        check_value("full_short",  64'(short_frame), 64'd0);
        check_value("full_busy",   64'(busy), 64'd0);

        // 3: short frame, last pixel coincides with frame_done -> 20 writes
        w0 = wr_cnt; d0 = done_cnt; exp_data = 12'h14A;
        arm();
        send(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 19; i++) send(1'b1, 16'h1234, 1'b0, 1'b0);
        send(1'b1, 16'h1234, 1'b1, 1'b0);
        idle(3);
        check_value("short_writes", 64'(wr_cnt - w0), 64'd20);
        check_value("short_done",   64'(done_cnt - d0), 64'd1);
        check_value("short_flag",   64'(short_frame), 64'd1);

        // 4: pixels while armed are dropped; first write is addr 0, data F00
        w0 = wr_cnt; d0 = done_cnt; exp_data = 12'hF00;
        arm();
        check_value("arm_clears_short", 64'(short_frame), 64'd0);
        for (int i = 0; i < 50; i++) send(1'b1, 16'hF800, 1'b0, 1'b0);
        check_value("armed_drop", 64'(wr_cnt - w0), 64'd0);
        check_value("armed_busy", 64'(busy), 64'd1);
        send(1'b0, 16'h0000, 1'b1, 1'b0);
        send(1'b1, 16'hF800, 1'b0, 1'b0);
        check_value("first_we",   64'(memory_we), 64'd1);
        check_value("first_addr", 64'(memory_addr), 64'd0);
        check_value("first_data", 64'(memory_data), 64'hF00);
        send(1'b1, 16'hF800, 1'b0, 1'b0);
        send(1'b1, 16'hF800, 1'b0, 1'b0);
        send(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(3);
        check_value("arm_writes", 64'(wr_cnt - w0), 64'd3);
        check_value("arm_done",   64'(done_cnt - d0), 64'd1);
        check_value("arm_short",  64'(short_frame), 64'd1);

        // 5: overrun by 10 pixels with capture_req toggled mid-capture
        w0 = wr_cnt; d0 = done_cnt; exp_data = 12'h0F0;
        arm();
        send(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < N + 10; i++)
            send(1'b1, 16'h07E0, 1'b0,
                 ((i >= 40) && (i < 42)) || ((i >= N - 5) && (i < N - 3)));
        idle(3);
        check_value("over_writes", 64'(wr_cnt - w0), 64'(N));
        check_value("over_done",   64'(done_cnt - d0), 64'd1);
        check_value("over_short",  64'(short_frame), 64'd0);
        check_value("over_busy",   64'(busy), 64'd0);

        // 6: capture_req held high across two frames
        w0 = wr_cnt; d0 = done_cnt; exp_data = 12'hFFF; busy_dropped = 1'b0;
        send(1'b0, 16'h0000, 1'b0, 1'b1);
        send(1'b0, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            send(1'b1, 16'hFFFF, 1'b0, 1'b1);
            busy_dropped = busy_dropped | ~busy;
        end
        for (int i = 0; i < 2; i++) begin
            send(1'b0, 16'h0000, 1'b0, 1'b1);
            busy_dropped = busy_dropped | ~busy;
        end
        send(1'b0, 16'h0000, 1'b1, 1'b1);
        busy_dropped = busy_dropped | ~busy;
        for (int i = 0; i < N; i++) send(1'b1, 16'hFFFF, 1'b0, 1'b0);
        idle(3);
`ifdef CAPTURE_CONTINUOUS_EN
        check_value("cont_writes",       64'(wr_cnt - w0), 64'(2 * N));
        check_value("cont_done",         64'(done_cnt - d0), 64'd2);
        check_value("cont_busy_between", 64'(busy_dropped), 64'd0);
`else
        check_value("single_writes", 64'(wr_cnt - w0), 64'(N));
        check_value("single_done",   64'(done_cnt - d0), 64'd1);
`endif
        check_value("end_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
